lcd_bus_receiver: RTL and testbench
===================================

Name: lcd_bus_receiver

Overview:
- Receiving end of the 8080-style parallel LCD write bus produced by the screen controller (lcd_db, lcd_wr, lcd_d_c, lcd_rd, lcd_reset).
- Decodes the CASET (0x2A), PASET (0x2B) and RAMWR (0x2C) command stream into addressed pixel writes. The output carries (x, y, RGB565) plus frame and command events.
- Sits in simulation benches and in an on-FPGA debug/loopback path, so LCD traffic can be checked against the VGA image or fed to a frame-buffer model.

Parameters:
- WIDTH, 320, panel columns; sets reset-default end column and x clamp.
- HEIGHT, 240, panel rows; sets reset-default end row and y clamp.
- SYNC_STAGES, 2, synchronizer flops on each bus input (minimum 2).

Ports:
- clk  in  1  sampling clock; at least 4x the lcd_wr toggle rate.
- reset  in  1  synchronous, active-high reset.
- lcd_db  in  8  bus data.
- lcd_wr  in  1  write strobe, active low; data captured on its rising edge.
- lcd_d_c  in  1  0 = command byte, 1 = data byte.
- lcd_rd  in  1  read strobe, active low.
- lcd_reset  in  1  panel reset, active low.
- pix_valid  out  1  one-cycle pulse: pix_x/pix_y/pix_rgb valid.
- pix_x  out  $clog2(WIDTH)  column of the current pixel.
- pix_y  out  $clog2(HEIGHT)  row of the current pixel.
- pix_rgb  out  16  RGB565 pixel; first bus byte = [15:8].
- frame_start  out  1  one-cycle pulse on each RAMWR command.
- cmd_valid  out  1  one-cycle pulse on every command byte.
- cmd_byte  out  8  last command byte.
- proto_err  out  1  sticky error flag; cleared by reset or panel reset.

Behaviour:
- Input synchronization:
  - Every bus input passes through SYNC_STAGES flops.
  - A write event is a 0->1 transition of the synchronized lcd_wr; lcd_db and lcd_d_c are sampled from the same synchronized stage.
  - Pin-to-output latency is fixed at SYNC_STAGES+1 clk after the rising edge of lcd_wr.
- Reset values:
  - All pulses = 0; pix_x = 0; pix_y = 0; pix_rgb = 0; cmd_byte = 0; proto_err = 0; state = IDLE.
  - Window: xs = 0, xe = WIDTH-1, ys = 0, ye = HEIGHT-1.
- Panel reset: synchronized lcd_reset = 0 has the same effect as reset on the state, window, byte phase and proto_err. Write events are ignored while it is low.
- Read strobe: write events with synchronized lcd_rd = 0 are ignored. Reads are not modelled.
- Command byte (d_c = 0):
  - Always pulses cmd_valid and loads cmd_byte.
  - Always clears the byte index and pixel half.
  - Next state: 0x2A -> CASET; 0x2B -> PASET; 0x2C -> RAMWR (also pulses frame_start, sets x = xs, y = ys); any other byte -> SKIP.
- CASET / PASET data bytes:
  - Byte index 0..3 loads start[15:8], start[7:0], end[15:8], end[7:0].
  - The new window takes effect after byte 3; bytes beyond index 3 are ignored.
  - If a new command arrives before byte 3, the partial values are discarded, the old window is kept, and proto_err is set.
- Window clamping (at commit):
  - end >= WIDTH (or HEIGHT) clamps to WIDTH-1 (or HEIGHT-1); start is clamped the same way.
  - If start > end, end is forced equal to start.
- RAMWR data bytes:
  - Even byte -> stored as the high half. Odd byte -> pix_rgb = {high, byte}, pix_x = x, pix_y = y, pix_valid pulses.
  - A new command with a half pixel pending drops that byte and sets proto_err.
- Address advance (after each emitted pixel):
  - If x == xe: x = xs, and y = (y == ye) ? ys : y+1.
  - Otherwise x = x+1.
- Data in IDLE or SKIP is ignored; data in IDLE also sets proto_err.
- Throughput: consecutive write events may arrive every 2 clk. Each event is fully processed in one clk, so there is no back-pressure.

Test Plan:
- Reset, then RAMWR plus 4 data bytes 0xF8,0x00,0x07,0xE0 -> frame_start pulses once; pixels (0,0,0xF800) and (1,0,0x07E0), each appearing 3 clk after its second wr edge.
- CASET 0,10,0,12; PASET 0,5,0,6; RAMWR plus 7 pixels -> coordinates (10,5) (11,5) (12,5) (10,6) (11,6) (12,6), then wrap to (10,5).
- CASET 0x01,0x50,0x01,0x60 (336..352) with WIDTH=320 -> xs = xe = 319; all subsequent pixels have x = 319 and y increments.
- CASET with only 2 data bytes, then RAMWR -> proto_err = 1; window unchanged (full screen); first pixel at (0,0).
- Mid-RAMWR: one odd byte, then lcd_reset low for 10 clk, then RAMWR plus 1 pixel -> no pixel from the orphan byte; proto_err = 0 after panel reset; pixel at (0,0).
- Command 0x36 plus 2 data bytes, then lcd_rd low during a data write -> cmd_valid and cmd_byte = 0x36; no pix_valid, no proto_err.

Source files
------------

// File: rtl/lcd_bus_receiver.sv
// rtl/lcd_bus_receiver.sv - 8080-style LCD write-bus receiver decoding CASET/PASET/RAMWR into pixel writes
module lcd_bus_receiver #(
  parameter int WIDTH       = 320,
  parameter int HEIGHT      = 240,
  parameter int SYNC_STAGES = 2,
  localparam int XW = $clog2(WIDTH),
  localparam int YW = $clog2(HEIGHT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    lcd_db,
  input  logic          lcd_wr,
  input  logic          lcd_d_c,
  input  logic          lcd_rd,
  input  logic          lcd_reset,
  output logic          pix_valid,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y,
  output logic [15:0]   pix_rgb,
  output logic          frame_start,
  output logic          cmd_valid,
  output logic [7:0]    cmd_byte,
  output logic          proto_err
);

  typedef enum logic [2:0] {IDLE, CASET, PASET, RAMWR, SKIP} state_t;

  logic [SYNC_STAGES-1:0] wr_sq, rd_sq, rst_sq, dc_sq;
  logic [7:0]             db_sq [SYNC_STAGES];
  logic                   wr_prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_sq     <= '1;
      rd_sq     <= '1;
      rst_sq    <= '1;
      dc_sq     <= '0;
      wr_prev_q <= 1'b1;
      for (int i = 0; i < SYNC_STAGES; i++) db_sq[i] <= '0;
    end else begin
      wr_sq     <= {wr_sq[SYNC_STAGES-2:0], lcd_wr};
      rd_sq     <= {rd_sq[SYNC_STAGES-2:0], lcd_rd};
      rst_sq    <= {rst_sq[SYNC_STAGES-2:0], lcd_reset};
      dc_sq     <= {dc_sq[SYNC_STAGES-2:0], lcd_d_c};
      wr_prev_q <= wr_sq[SYNC_STAGES-1];
      db_sq[0]  <= lcd_db;
      for (int i = 1; i < SYNC_STAGES; i++) db_sq[i] <= db_sq[i-1];
    end
  end

  logic       rst_s, dc_s, write_ev;
  logic [7:0] db_s;
  assign rst_s    = rst_sq[SYNC_STAGES-1];
  assign dc_s     = dc_sq[SYNC_STAGES-1];
  assign db_s     = db_sq[SYNC_STAGES-1];
  assign write_ev = wr_sq[SYNC_STAGES-1] & ~wr_prev_q & rd_sq[SYNC_STAGES-1] & rst_s;

  function automatic logic [XW-1:0] clamp_x(input logic [15:0] v);
    if (32'(v) >= WIDTH) return XW'(WIDTH - 1);
    return v[XW-1:0];
  endfunction

  function automatic logic [YW-1:0] clamp_y(input logic [15:0] v);
    if (32'(v) >= HEIGHT) return YW'(HEIGHT - 1);
    return v[YW-1:0];
  endfunction

  state_t        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic          half_q, half_d;
  logic [7:0]    hi_q, hi_d;
  logic [23:0]   par_q, par_d;
  logic [XW-1:0] xs_q, xs_d, xe_q, xe_d, x_q, x_d, pix_x_q, pix_x_d;
  logic [YW-1:0] ys_q, ys_d, ye_q, ye_d, y_q, y_d, pix_y_q, pix_y_d;
  logic [15:0]   pix_rgb_q, pix_rgb_d;
  logic [7:0]    cmd_byte_q, cmd_byte_d;
  logic          pix_valid_q, pix_valid_d, frame_start_q, frame_start_d;
  logic          cmd_valid_q, cmd_valid_d, proto_err_q, proto_err_d;

  // Candidate window at commit: start from bytes 0-1, end from byte 2 plus the current byte.
  logic [XW-1:0] cx_s, cx_e_raw, cx_e;
  logic [YW-1:0] cy_s, cy_e_raw, cy_e;
  assign cx_s     = clamp_x(par_q[23:8]);
  assign cx_e_raw = clamp_x({par_q[7:0], db_s});
  assign cx_e     = (cx_s > cx_e_raw) ? cx_s : cx_e_raw;
  assign cy_s     = clamp_y(par_q[23:8]);
  assign cy_e_raw = clamp_y({par_q[7:0], db_s});
  assign cy_e     = (cy_s > cy_e_raw) ? cy_s : cy_e_raw;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    half_d        = half_q;
    hi_d          = hi_q;
    par_d         = par_q;
    xs_d          = xs_q;
    xe_d          = xe_q;
    ys_d          = ys_q;
    ye_d          = ye_q;
    x_d           = x_q;
    y_d           = y_q;
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    pix_rgb_d     = pix_rgb_q;
    cmd_byte_d    = cmd_byte_q;
    proto_err_d   = proto_err_q;
    pix_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    cmd_valid_d   = 1'b0;
    if (!rst_s) begin
      state_d     = IDLE;
      idx_d       = '0;
      half_d      = 1'b0;
      xs_d        = '0;
      xe_d        = XW'(WIDTH - 1);
      ys_d        = '0;
      ye_d        = YW'(HEIGHT - 1);
      proto_err_d = 1'b0;
    end else if (write_ev && !dc_s) begin
      cmd_valid_d = 1'b1;
      cmd_byte_d  = db_s;
      idx_d       = '0;
      half_d      = 1'b0;
      if ((state_q == CASET || state_q == PASET) && idx_q != 3'd0 && idx_q < 3'd4)
        proto_err_d = 1'b1;
      if (state_q == RAMWR && half_q)
        proto_err_d = 1'b1;
      case (db_s)
        8'h2A:   state_d = CASET;
        8'h2B:   state_d = PASET;
        8'h2C: begin
          state_d       = RAMWR;
          frame_start_d = 1'b1;
          x_d           = xs_q;
          y_d           = ys_q;
        end
        default: state_d = SKIP;
      endcase
    end else if (write_ev) begin
      case (state_q)
        IDLE: proto_err_d = 1'b1;
        CASET, PASET: begin
          if (idx_q < 3'd4) idx_d = idx_q + 3'd1;
          case (idx_q)
            3'd0: par_d[23:16] = db_s;
            3'd1: par_d[15:8]  = db_s;
            3'd2: par_d[7:0]   = db_s;
            3'd3: begin
              if (state_q == CASET) begin
                xs_d = cx_s;
                xe_d = cx_e;
              end else begin
                ys_d = cy_s;
                ye_d = cy_e;
              end
            end
            default: ;
          endcase
        end
        RAMWR: begin
          if (!half_q) begin
            hi_d   = db_s;
            half_d = 1'b1;
          end else begin
            half_d      = 1'b0;
            pix_valid_d = 1'b1;
            pix_rgb_d   = {hi_q, db_s};
            pix_x_d     = x_q;
            pix_y_d     = y_q;
            if (x_q == xe_q) begin
              x_d = xs_q;
              y_d = (y_q == ye_q) ? ys_q : y_q + YW'(1);
            end else begin
              x_d = x_q + XW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      half_q        <= 1'b0;
      hi_q          <= '0;
      par_q         <= '0;
      xs_q          <= '0;
      xe_q          <= XW'(WIDTH - 1);
      ys_q          <= '0;
      ye_q          <= YW'(HEIGHT - 1);
      x_q           <= '0;
      y_q           <= '0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_rgb_q     <= '0;
      cmd_byte_q    <= '0;
      proto_err_q   <= 1'b0;
      pix_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      cmd_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      half_q        <= half_d;
      hi_q          <= hi_d;
      par_q         <= par_d;
      xs_q          <= xs_d;
      xe_q          <= xe_d;
      ys_q          <= ys_d;
      ye_q          <= ye_d;
      x_q           <= x_d;
      y_q           <= y_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      pix_rgb_q     <= pix_rgb_d;
      cmd_byte_q    <= cmd_byte_d;
      proto_err_q   <= proto_err_d;
      pix_valid_q   <= pix_valid_d;
      frame_start_q <= frame_start_d;
      cmd_valid_q   <= cmd_valid_d;
    end
  end

  assign pix_valid   = pix_valid_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_rgb     = pix_rgb_q;
  assign frame_start = frame_start_q;
  assign cmd_valid   = cmd_valid_q;
  assign cmd_byte    = cmd_byte_q;
  assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// tb/tb_lcd_bus_receiver.sv - directed self-checking bench for lcd_bus_receiver
module tb_lcd_bus_receiver;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] lcd_db = 8'h00;
  logic       lcd_wr = 1'b1;
  logic       lcd_d_c = 1'b0;
  logic       lcd_rd = 1'b1;
  logic       lcd_reset = 1'b1;
  logic       pix_valid, frame_start, cmd_valid, proto_err;
  logic [8:0] pix_x;
  logic [7:0] pix_y;
  logic [15:0] pix_rgb;
  logic [7:0] cmd_byte;

  int n_checks = 0;
  int n_fail = 0;

  lcd_bus_receiver #(.WIDTH(320), .HEIGHT(240), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .lcd_db(lcd_db), .lcd_wr(lcd_wr), .lcd_d_c(lcd_d_c),
    .lcd_rd(lcd_rd), .lcd_reset(lcd_reset), .pix_valid(pix_valid), .pix_x(pix_x),
    .pix_y(pix_y), .pix_rgb(pix_rgb), .frame_start(frame_start), .cmd_valid(cmd_valid),
    .cmd_byte(cmd_byte), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  logic [8:0]  q_x [$];
  logic [7:0]  q_y [$];
  logic [15:0] q_rgb [$];
  int n_frame = 0;
  int n_cmd = 0;

  always @(negedge clk) begin
    if (pix_valid) begin
      q_x.push_back(pix_x);
      q_y.push_back(pix_y);
      q_rgb.push_back(pix_rgb);
    end
    if (frame_start) n_frame++;
    if (cmd_valid) n_cmd++;
  end

  task automatic do_reset();
    reset = 1'b1;
    lcd_wr = 1'b1;
    lcd_rd = 1'b1;
    lcd_reset = 1'b1;
    lcd_d_c = 1'b0;
    lcd_db = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    q_x.delete();
    q_y.delete();
    q_rgb.delete();
    n_frame = 0;
    n_cmd = 0;
  endtask

  // pv_at: clocks after the wr rising edge at which pix_valid was first seen (0 = none)
  task automatic wr_byte(input logic dc, input logic [7:0] d, output int pv_at);
    @(negedge clk);
    lcd_db = d;
    lcd_d_c = dc;
    lcd_wr = 1'b0;
    repeat (2) @(negedge clk);
    lcd_wr = 1'b1;
    pv_at = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (pix_valid && pv_at == 0) pv_at = k;
    end
  endtask

  task automatic cmd(input logic [7:0] b);
    int unused_pv;
    wr_byte(1'b0, b, unused_pv);
  endtask

  task automatic dat(input logic [7:0] b);
    int unused_pv;
    wr_byte(1'b1, b, unused_pv);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pix_valid got %b want 0", pix_valid); end
    n_checks++; if (pix_x !== 9'd0 || pix_y !== 8'd0) begin n_fail++; $display("FAIL reset_xy got (%0d,%0d) want (0,0)", pix_x, pix_y); end
    n_checks++; if (pix_rgb !== 16'h0000) begin n_fail++; $display("FAIL reset_rgb got %h want 0000", pix_rgb); end
    n_checks++; if (cmd_byte !== 8'h00) begin n_fail++; $display("FAIL reset_cmd_byte got %h want 00", cmd_byte); end
    n_checks++; if (proto_err !== 1'b0 || frame_start !== 1'b0 || cmd_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags got err=%b fs=%b cv=%b want 0", proto_err, frame_start, cmd_valid);
    end
  endtask

  task automatic test_ramwr_basic();
    int pv;
    do_reset();
    cmd(8'h2C);
    wr_byte(1'b1, 8'hF8, pv);
    n_checks++; if (pv !== 0) begin n_fail++; $display("FAIL basic_half_no_pixel got %0d want 0", pv); end
    wr_byte(1'b1, 8'h00, pv);
    n_checks++; if (pv !== 3) begin n_fail++; $display("FAIL basic_latency0 got %0d want 3", pv); end
    dat(8'h07);
    wr_byte(1'b1, 8'hE0, pv);
    n_checks++; if (pv !== 3) begin n_fail++; $display("FAIL basic_latency1 got %0d want 3", pv); end
    n_checks++; if (n_frame !== 1) begin n_fail++; $display("FAIL basic_frame_start got %0d want 1", n_frame); end
    n_checks++; if (cmd_byte !== 8'h2C || n_cmd !== 1) begin n_fail++; $display("FAIL basic_cmd got %h/%0d want 2c/1", cmd_byte, n_cmd); end
    n_checks++;
    if (q_x.size() !== 2) begin
      n_fail++; $display("FAIL basic_count got %0d want 2", q_x.size());
    end else begin
      if (q_x[0] !== 9'd0 || q_y[0] !== 8'd0 || q_rgb[0] !== 16'hF800) begin
        n_fail++; $display("FAIL basic_pix0 got (%0d,%0d,%h) want (0,0,f800)", q_x[0], q_y[0], q_rgb[0]);
      end
      n_checks++;
      if (q_x[1] !== 9'd1 || q_y[1] !== 8'd0 || q_rgb[1] !== 16'h07E0) begin
        n_fail++; $display("FAIL basic_pix1 got (%0d,%0d,%h) want (1,0,07e0)", q_x[1], q_y[1], q_rgb[1]);
      end
    end
  endtask

  task automatic test_window();
    logic [8:0] ex [7];
    logic [7:0] ey [7];
    ex = '{9'd10, 9'd11, 9'd12, 9'd10, 9'd11, 9'd12, 9'd10};
    ey = '{8'd5, 8'd5, 8'd5, 8'd6, 8'd6, 8'd6, 8'd5};
    do_reset();
    cmd(8'h2A); dat(8'd0); dat(8'd10); dat(8'd0); dat(8'd12);
    cmd(8'h2B); dat(8'd0); dat(8'd5); dat(8'd0); dat(8'd6);
    cmd(8'h2C);
    for (int i = 0; i < 7; i++) begin
      dat(8'(i + 1));
      dat(8'(8'h40 + i));
    end
    n_checks++;
    if (q_x.size() !== 7) begin
      n_fail++; $display("FAIL window_count got %0d want 7", q_x.size());
    end else begin
      for (int i = 0; i < 7; i++) begin
        n_checks++;
        if (q_x[i] !== ex[i] || q_y[i] !== ey[i] || q_rgb[i] !== {8'(i + 1), 8'(8'h40 + i)}) begin
          n_fail++;
          $display("FAIL window_pix%0d got (%0d,%0d,%h) want (%0d,%0d,%h)", i, q_x[i], q_y[i], q_rgb[i],
                   ex[i], ey[i], {8'(i + 1), 8'(8'h40 + i)});
        end
      end
    end
    n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL window_err got %b want 0", proto_err); end
  endtask

  task automatic test_clamp();
    do_reset();
    cmd(8'h2A); dat(8'h01); dat(8'h50); dat(8'h01); dat(8'h60);
    cmd(8'h2C);
    for (int i = 0; i < 3; i++) begin
      dat(8'hAA);
      dat(8'(i));
    end
    n_checks++;
    if (q_x.size() !== 3) begin
      n_fail++; $display("FAIL clamp_count got %0d want 3", q_x.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (q_x[i] !== 9'd319 || q_y[i] !== 8'(i)) begin
          n_fail++; $display("FAIL clamp_pix%0d got (%0d,%0d) want (319,%0d)", i, q_x[i], q_y[i], i);
        end
      end
    end
  endtask

  task automatic test_partial_caset();
    do_reset();
    cmd(8'h2A); dat(8'h00); dat(8'h05);
    cmd(8'h2C);
    n_checks++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL partial_err got %b want 1", proto_err); end
    dat(8'hAA); dat(8'h55);
    dat(8'h12); dat(8'h34);
    n_checks++;
    if (q_x.size() !== 2) begin
      n_fail++; $display("FAIL partial_count got %0d want 2", q_x.size());
    end else begin
      if (q_x[0] !== 9'd0 || q_y[0] !== 8'd0 || q_rgb[0] !== 16'hAA55) begin
        n_fail++; $display("FAIL partial_pix0 got (%0d,%0d,%h) want (0,0,aa55)", q_x[0], q_y[0], q_rgb[0]);
      end
      n_checks++;
      if (q_x[1] !== 9'd1 || q_y[1] !== 8'd0) begin
        n_fail++; $display("FAIL partial_pix1 got (%0d,%0d) want (1,0)", q_x[1], q_y[1]);
      end
    end
  endtask

  task automatic test_panel_reset();
    do_reset();
    dat(8'h99);
    n_checks++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL idle_data_err got %b want 1", proto_err); end
    cmd(8'h2C);
    dat(8'h12);
    @(negedge clk);
    lcd_reset = 1'b0;
    repeat (10) @(negedge clk);
    lcd_reset = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL panel_reset_err got %b want 0", proto_err); end
    cmd(8'h2C);
    dat(8'h34); dat(8'h56);
    n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL panel_after_err got %b want 0", proto_err); end
    n_checks++;
    if (q_x.size() !== 1) begin
      n_fail++; $display("FAIL panel_count got %0d want 1", q_x.size());
    end else if (q_x[0] !== 9'd0 || q_y[0] !== 8'd0 || q_rgb[0] !== 16'h3456) begin
      n_fail++; $display("FAIL panel_pix got (%0d,%0d,%h) want (0,0,3456)", q_x[0], q_y[0], q_rgb[0]);
    end
  endtask

  task automatic test_skip_and_read();
    do_reset();
    cmd(8'h36); dat(8'h01); dat(8'h02);
    lcd_rd = 1'b0;
    dat(8'h03);
    lcd_rd = 1'b1;
    n_checks++; if (cmd_byte !== 8'h36 || n_cmd !== 1) begin n_fail++; $display("FAIL skip_cmd got %h/%0d want 36/1", cmd_byte, n_cmd); end
    n_checks++; if (q_x.size() !== 0 || n_frame !== 0) begin n_fail++; $display("FAIL skip_no_pixel got %0d/%0d want 0/0", q_x.size(), n_frame); end
    n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL skip_err got %b want 0", proto_err); end
    cmd(8'h2C);
    dat(8'hAB);
    lcd_rd = 1'b0;
    dat(8'hFF);
    lcd_rd = 1'b1;
    dat(8'hCD);
    n_checks++;
    if (q_x.size() !== 1) begin
      n_fail++; $display("FAIL read_gate_count got %0d want 1", q_x.size());
    end else if (q_rgb[0] !== 16'hABCD || q_x[0] !== 9'd0 || q_y[0] !== 8'd0) begin
      n_fail++; $display("FAIL read_gate_pix got (%0d,%0d,%h) want (0,0,abcd)", q_x[0], q_y[0], q_rgb[0]);
    end
  endtask

  initial begin
    test_reset();
    test_ramwr_basic();
    test_window();
    test_clamp();
    test_partial_caset();
    test_panel_reset();
    test_skip_and_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
